// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, parameter
// defaults and the phase-counter sizing helper.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILISE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int DEFAULT_SYNC_STAGES        = 3;
    localparam int DEFAULT_LOCK_STABLE_CYCLES = 1024;
    localparam int DEFAULT_RESET_HOLD_CYCLES  = 16;
    localparam int DEFAULT_LOSS_COUNT_WIDTH   = 8;

    // Counter only needs to reach max(a,b)-1; never narrower than one bit.
    function automatic int phase_cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Lock/soft-reset inputs and core-reset/status outputs of the reset sequencer.
interface reset_sequencer_if
    import reset_sequencer_pkg::*;
#(
    parameter int LOSS_COUNT_WIDTH = DEFAULT_LOSS_COUNT_WIDTH
);
    logic                        i_locked;
    logic                        i_soft_reset;
    logic                        o_reset;
    logic                        o_ready;
    logic [1:0]                  o_state;
    logic [LOSS_COUNT_WIDTH-1:0] o_lock_loss_count;

    modport master (
        input  i_locked,
        input  i_soft_reset,
        output o_reset,
        output o_ready,
        output o_state,
        output o_lock_loss_count
    );

    modport slave (
        output i_locked,
        output i_soft_reset,
        input  o_reset,
        input  o_ready,
        input  o_state,
        input  o_lock_loss_count
    );
endinterface

// File: rtl/bit_synchronizer.sv
// Parameterised-depth flop chain bringing a single asynchronous bit into the
// clk domain; cleared to 0 asynchronously.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_reg;
    logic [STAGES-1:0] sync_next;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_next[gi] = d;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign q = sync_reg[STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// Core reset sequencer: qualifies MMCM lock, holds the core in reset for a
// fixed time, and re-enters reset on lock loss or software request.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES        = DEFAULT_SYNC_STAGES,
    parameter int LOCK_STABLE_CYCLES = DEFAULT_LOCK_STABLE_CYCLES,
    parameter int RESET_HOLD_CYCLES  = DEFAULT_RESET_HOLD_CYCLES,
    parameter int LOSS_COUNT_WIDTH   = DEFAULT_LOSS_COUNT_WIDTH
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    reset_sequencer_if.master  bus
);
    localparam int CNT_W = phase_cnt_width(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [LOSS_COUNT_WIDTH-1:0] LOSS_MAX = '1;

    logic                        locked_s;
    state_t                      state_reg, state_next;
    logic [CNT_W-1:0]            cnt_reg, cnt_next;
    logic [LOSS_COUNT_WIDTH-1:0] loss_reg, loss_next;
    logic                        reset_reg;
    logic                        ready_reg;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (i_clock),
        .rst_n (i_reset_n),
        .d     (bus.i_locked),
        .q     (locked_s)
    );

    // Outputs are registered from state_next so they move with the state register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= WAIT_LOCK;
            cnt_reg   <= '0;
            loss_reg  <= '0;
            reset_reg <= 1'b1;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            loss_reg  <= loss_next;
            reset_reg <= (state_next != RUN);
            ready_reg <= (state_next == RUN);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        loss_next  = loss_reg;
        case (state_reg)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = STABILISE;
                    cnt_next   = '0;
                end
            end
            STABILISE: begin
                cnt_next = cnt_reg + 1'b1;
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end
            end
            HOLD: begin
                cnt_next = cnt_reg + 1'b1;
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                end else if (cnt_reg == HOLD_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // Lock loss wins over a simultaneous soft reset request.
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    if (loss_reg != LOSS_MAX) begin
                        loss_next = loss_reg + 1'b1;
                    end
                end else if (bus.i_soft_reset) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
            end
        endcase
    end

    assign bus.o_reset           = reset_reg;
    assign bus.o_ready           = ready_reg;
    assign bus.o_state           = state_reg;
    assign bus.o_lock_loss_count = loss_reg;
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits between the MMCM and the `top` core.
- Consumes the board reset and the MMCM LOCKED signal, and produces a glitch-free, synchronously released active-high core reset.
- Holds the core in reset until lock has been stable for a programmable time, then for a further hold time.
- Re-enters reset on lock loss or on a software reset request, and counts lock-loss events.

Parameters:
- SYNC_STAGES, 3: flop depth of the i_locked synchroniser; minimum 2.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before the hold phase; minimum 1.
- RESET_HOLD_CYCLES, 16: cycles o_reset stays high after lock is qualified; minimum 1.
- LOSS_COUNT_WIDTH, 8: width of the lock-loss counter.

Ports:
- i_clock  input  1  MMCM-derived core clock (BUFG output).
- i_reset_n  input  1  asynchronous active-low reset; asserts o_reset immediately.
- i_locked  input  1  MMCM LOCKED; asynchronous to i_clock.
- i_soft_reset  input  1  synchronous core-reset request; level-sampled, acted on only in RUN.
- o_reset  output  1  active-high reset to the core; registered.
- o_ready  output  1  high only in RUN; registered.
- o_state  output  2  current FSM state, for debug.
- o_lock_loss_count  output  LOSS_COUNT_WIDTH  saturating count of lock losses while in RUN.

Behaviour:
- Reset (i_reset_n low, asynchronous):
  - state = WAIT_LOCK, o_reset = 1 (async set), o_ready = 0, o_lock_loss_count = 0.
  - Synchroniser cleared to 0; phase counter = 0.
- locked_s: last stage of the SYNC_STAGES chain sampling i_locked.
- State encoding: WAIT_LOCK=0, STABILISE=1, HOLD=2, RUN=3.
- WAIT_LOCK:
  - locked_s=1 -> STABILISE, counter cleared.
- STABILISE:
  - Counter increments each cycle.
  - locked_s=0 -> WAIT_LOCK; loss counter unchanged.
  - Counter == LOCK_STABLE_CYCLES-1 with locked_s=1 -> HOLD, counter cleared.
- HOLD:
  - Counter increments each cycle.
  - locked_s=0 -> WAIT_LOCK.
  - Counter == RESET_HOLD_CYCLES-1 -> RUN.
- RUN:
  - locked_s=0 -> WAIT_LOCK; o_lock_loss_count += 1, saturating at all-ones.
  - Otherwise i_soft_reset=1 -> HOLD, counter cleared.
  - Lock loss has priority over i_soft_reset in the same cycle.
- Output timing:
  - o_reset = (next_state != RUN) and o_ready = (next_state == RUN), both registered.
  - Both therefore change on the same edge the state register changes; no combinational path to outputs.
- i_soft_reset is ignored in WAIT_LOCK, STABILISE and HOLD.
- Counter width: clog2(max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES)); it never wraps because it is cleared on each phase entry.
- Release latency with i_locked steady high from reset release: o_reset falls on edge N = SYNC_STAGES + 1 + LOCK_STABLE_CYCLES + RESET_HOLD_CYCLES after the first edge with i_reset_n high.
- Lock-loss assertion latency: o_reset rises on edge SYNC_STAGES+1 after i_locked falls.
- Soft reset: sampled high on edge k in RUN -> o_reset high after edge k, low again after edge k+RESET_HOLD_CYCLES.
- Mid-operation reset: i_reset_n low at any time asserts o_reset without waiting for a clock edge and clears the loss counter.
- o_lock_loss_count is cleared only by i_reset_n.

Decomposition:
- Shared header reset_sequencer_pkg: state encoding localparams (WAIT_LOCK, STABILISE, HOLD, RUN) and parameter defaults.
- One sub-module, bit_synchronizer: SYNC_STAGES-deep flop chain with async active-low clear and parameterised depth. Reused for i_uart_rx.
- FSM, phase counter and loss counter stay in reset_sequencer.

Test Plan:
All scenarios use SYNC_STAGES=3, LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4, LOSS_COUNT_WIDTH=8.
1. Power-up: i_locked=1, release i_reset_n -> o_reset falls and o_ready rises on exactly edge 16; o_state walks 0,1,2,3; o_lock_loss_count=0.
2. Lock glitch in STABILISE: drop i_locked for 5 cycles at edge 7 -> o_state returns to 0; o_reset stays 1; count stays 0; after relock a full 8-cycle STABILISE is observed before HOLD.
3. Lock loss in RUN: drop i_locked -> o_reset=1 on 4th edge; o_lock_loss_count=1; on relock o_reset falls 16 edges after i_locked rises.
4. Soft reset in RUN: 1-cycle pulse -> o_reset high for exactly 4 cycles, o_state=2 then 3, count unchanged. Pulse during HOLD -> no extension.
5. Simultaneous soft reset and lock loss in RUN: o_state goes to 0 (not 2) and count increments. Separately, 300 lock-loss events -> o_lock_loss_count=255.
6. Async reset mid-RUN: i_reset_n falls between edges -> o_reset=1 before the next edge; o_ready=0; count=0; full 16-edge sequence repeats after release.
